alu_op_sequencer: RTL



---
 rtl/alu_seq_pkg.sv | 54 +++++
 rtl/alu_op_sequencer_if.sv | 48 ++++
 rtl/alu_seq_cond.sv | 37 +++
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared states, funct3 codes and ALU select encodings for alu_op_sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // {S2,S1,S0,Cin}
    localparam logic [3:0] ALU_SEL_ADD = 4'b0000;
    localparam logic [3:0] ALU_SEL_SUB = 4'b0011;
    localparam logic [3:0] ALU_SEL_AND = 4'b1000;
    localparam logic [3:0] ALU_SEL_OR  = 4'b1001;
    localparam logic [3:0] ALU_SEL_XOR = 4'b1010;

    // Shifts never reach this: they keep the ALU on ADD (all selects low).
    function automatic logic [3:0] sel_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_imm, input logic is_br);
        logic [3:0] sel;
        sel = ALU_SEL_ADD;
        if (is_br) begin
            sel = ALU_SEL_SUB;
        end else begin
            case (f3)
                F3_ADD:          sel = (f7b5 && !is_imm) ? ALU_SEL_SUB : ALU_SEL_ADD;
                F3_SLT, F3_SLTU: sel = ALU_SEL_SUB;
                F3_XOR:          sel = ALU_SEL_XOR;
                F3_OR:           sel = ALU_SEL_OR;
                F3_AND:          sel = ALU_SEL_AND;
                default:         sel = ALU_SEL_ADD;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request, ALU and response signals of alu_op_sequencer
interface alu_op_sequencer_if #(parameter int SIZE = 32);

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic            req_funct7b5;
    logic            req_is_imm;
    logic            req_is_branch;
    logic [SIZE-1:0] req_a;
    logic [SIZE-1:0] req_b;

    logic [SIZE-1:0] alu_a;
    logic [SIZE-1:0] alu_b;
    logic            alu_s2;
    logic            alu_s1;
    logic            alu_s0;
    logic            alu_cin;
    logic [SIZE-1:0] alu_y;
    logic            alu_v;
    logic            alu_c;
    logic            alu_n;
    logic            alu_z;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [SIZE-1:0] rsp_result;
    logic            rsp_taken;

    modport master (
        input  req_valid, req_funct3, req_funct7b5, req_is_imm, req_is_branch, req_a, req_b,
        output req_ready,
        output alu_a, alu_b, alu_s2, alu_s1, alu_s0, alu_cin,
        input  alu_y, alu_v, alu_c, alu_n, alu_z,
        output rsp_valid, rsp_result, rsp_taken,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_funct3, req_funct7b5, req_is_imm, req_is_branch, req_a, req_b,
        input  req_ready,
        input  alu_a, alu_b, alu_s2, alu_s1, alu_s0, alu_cin,
        output alu_y, alu_v, alu_c, alu_n, alu_z,
        input  rsp_valid, rsp_result, rsp_taken,
        output rsp_ready
    );

endinterface

// File: rtl/alu_seq_cond.sv
// rtl/alu_seq_cond.sv - funct3 + V/C/N/Z to SLT/SLTU bit and branch outcome
// Branch outcome only exists when ALU_SEQ_BRANCH_EN is defined; otherwise taken is 0.
module alu_seq_cond
    import alu_seq_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       v,
    input  logic       c,
    input  logic       n,
    input  logic       z,
    output logic       slt_bit,
    output logic       taken
);

    // Flags come from A-B: signed less-than is N^V, unsigned less-than is a borrow (~C).
    assign slt_bit = (funct3 == F3_SLTU) ? ~c : (n ^ v);

`ifdef ALU_SEQ_BRANCH_EN
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = z;
            F3_BNE:  taken = ~z;
            F3_BLT:  taken = n ^ v;
            F3_BGE:  taken = ~(n ^ v);
            F3_BLTU: taken = ~c;
            F3_BGEU: taken = c;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_z;
    assign unused_z = z;
    assign taken    = 1'b0;
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle RV32I op/branch initiator around an external shifterless ALU
// Branch handling is built only when ALU_SEQ_BRANCH_EN is defined.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.master bus
);

    state_t               state;
    state_t               state_nxt;
    logic [SHAMT_W-1:0]   cnt;
    logic [2:0]           op_f3;
    logic                 op_f7b5;
    logic                 op_br;
    logic [3:0]           sel;
    logic [SIZE-1:0]      a_q;
    logic [SIZE-1:0]      b_q;
    logic [SIZE-1:0]      res_q;
    logic                 taken_q;

    logic                 req_fire;
    logic                 req_br;
    logic                 req_shift;
    logic                 slt_bit;
    logic                 cond_taken;
    logic [SIZE-1:0]      shifted;
    logic [SIZE-1:0]      exec_result;

`ifdef ALU_SEQ_BRANCH_EN
    assign req_br = bus.req_is_branch;
`else
    logic unused_br;
    assign unused_br = bus.req_is_branch;
    assign req_br    = 1'b0;
`endif

    assign req_fire  = bus.req_valid && (state == ST_IDLE);
    assign req_shift = !req_br && ((bus.req_funct3 == F3_SLL) || (bus.req_funct3 == F3_SRL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_fire) state_nxt = req_shift ? ST_SHIFT : ST_EXEC;
            ST_EXEC:  state_nxt = ST_RESP;
            ST_SHIFT: if (cnt == '0) state_nxt = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    alu_seq_cond u_cond (
        .funct3  (op_f3),
        .v       (bus.alu_v),
        .c       (bus.alu_c),
        .n       (bus.alu_n),
        .z       (bus.alu_z),
        .slt_bit (slt_bit),
        .taken   (cond_taken)
    );

    always_comb begin
        exec_result = bus.alu_y;
        if (!op_br && ((op_f3 == F3_SLT) || (op_f3 == F3_SLTU))) begin
            exec_result = {{(SIZE-1){1'b0}}, slt_bit};
        end
    end

    // alu_a doubles as the shift working register; the ALU is parked on ADD meanwhile.
    always_comb begin
        if (op_f3 == F3_SLL) begin
            shifted = {a_q[SIZE-2:0], 1'b0};
        end else if (op_f7b5) begin
            shifted = {a_q[SIZE-1], a_q[SIZE-1:1]};
        end else begin
            shifted = {1'b0, a_q[SIZE-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_f3   <= '0;
            op_f7b5 <= 1'b0;
            op_br   <= 1'b0;
            sel     <= ALU_SEL_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        a_q     <= bus.req_a;
                        b_q     <= bus.req_b;
                        op_f3   <= bus.req_funct3;
                        op_f7b5 <= bus.req_funct7b5;
                        op_br   <= req_br;
                        cnt     <= req_shift ? bus.req_b[SHAMT_W-1:0] : '0;
                        sel     <= req_shift ? ALU_SEL_ADD
                                             : sel_decode(bus.req_funct3, bus.req_funct7b5,
                                                          bus.req_is_imm, req_br);
                    end
                end
                ST_EXEC: begin
                    res_q   <= exec_result;
                    taken_q <= op_br & cond_taken;
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        a_q <= shifted;
                        cnt <= cnt - SHAMT_W'(1);
                    end else begin
                        res_q   <= a_q;
                        taken_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.rsp_result = res_q;
    assign bus.rsp_taken  = taken_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign {bus.alu_s2, bus.alu_s1, bus.alu_s0, bus.alu_cin} = sel;

endmodule
